m_rdbuf: RTL and testbench

- Return-direction companion to the write-side bus buffering: captures read data arriving from the memory/peripheral side and holds it until the CPU side consumes it.
- Small synchronous FIFO with a strobe-in / valid-ack-out handshake, an occupancy count, and a sticky overflow flag.
- Sits between the memory-interface data return path and the CPU data-in mux.

---
 rtl/m_rdbuf_if.sv | 28 ++
 rtl/m_rdbuf.sv | 101 ++++++++++
 tb/tb_m_rdbuf.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/m_rdbuf_if.sv
// Bus bundle for the read-return buffer.
// The master pushes and acknowledges; the slave (the buffer) reports head and status.
interface m_rdbuf_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic             flush;
  logic             wr_stb;
  logic [WIDTH-1:0] wr_data;
  logic             rd_ack;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic [AW:0]      count;
  logic             full;
  logic             ovf;

  modport master (
    output flush, wr_stb, wr_data, rd_ack,
    input  rd_valid, rd_data, count, full, ovf
  );

  modport slave (
    input  flush, wr_stb, wr_data, rd_ack,
    output rd_valid, rd_data, count, full, ovf
  );
endinterface

// File: rtl/m_rdbuf.sv
// Read-return buffer: small synchronous FIFO between the memory data return
// path and the CPU data-in mux. Strobe-in / valid-ack-out, occupancy count,
// sticky overflow flag. All outputs come straight from registers, so there is
// no combinational path from wr_stb, wr_data or rd_ack to any output.
module m_rdbuf #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input logic      clock,
  input logic      reset,
  m_rdbuf_if.slave bus
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             ovf_q, ovf_d;

  logic is_empty;
  logic is_full;
  logic pop_acc;
  logic push_acc;
  logic push_drop;
  logic wr_en;

  assign is_empty  = (count_q == '0);
  assign is_full   = (count_q == FULL_CNT);
  // A pop needs a valid head; a push into a full buffer is only allowed when
  // the head is leaving in the same cycle, so the new word takes the freed slot.
  assign pop_acc   = bus.rd_ack && !is_empty;
  assign push_acc  = bus.wr_stb && (!is_full || pop_acc);
  assign push_drop = bus.wr_stb && is_full && !pop_acc;
  // Flush discards any push in the same cycle, so storage is left untouched.
  assign wr_en     = push_acc && !bus.flush;

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_acc) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push_acc && !pop_acc) begin
        count_d = count_q + 1'b1;
      end else if (pop_acc && !push_acc) begin
        count_d = count_q - 1'b1;
      end
      if (push_drop) begin
        ovf_d = 1'b1;
      end
    end
  end

  // Control state register; reset overrides flush and all traffic.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage: cleared by reset (so rd_data reads 0 afterwards), kept on flush.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  assign bus.rd_valid = !is_empty;
  assign bus.rd_data  = mem_q[rd_ptr_q];
  assign bus.count    = count_q;
  assign bus.full     = is_full;
  assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_m_rdbuf.sv
// Testbench for m_rdbuf: directed scenarios plus a randomized run, all
// checked against a queue-based reference model.
module tb_m_rdbuf;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clock;
  logic reset;

  m_rdbuf_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  m_rdbuf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: FIFO contents as a queue, plus the sticky flag.
  logic [WIDTH-1:0] model_q[$];
  bit               model_ovf;

  // Apply the current inputs to the model (called just before the clock edge).
  task automatic model_apply();
    bit popped;
    if (reset || bus.flush) begin
      model_q.delete();
      model_ovf = 1'b0;
    end else begin
      popped = 1'b0;
      if (bus.rd_ack && model_q.size() > 0) begin
        void'(model_q.pop_front());
        popped = 1'b1;
      end
      if (bus.wr_stb) begin
        if (model_q.size() < DEPTH) model_q.push_back(bus.wr_data);
        else if (!popped) model_ovf = 1'b1;
      end
    end
  endtask

  task automatic tick();
    model_apply();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.flush = 1'b0; bus.wr_stb = 1'b0; bus.rd_ack = 1'b0; bus.wr_data = '0;
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    bus.wr_stb = 1'b1; bus.wr_data = d; bus.rd_ack = 1'b0;
    tick();
    bus.wr_stb = 1'b0;
  endtask

  task automatic do_flush();
    idle(); bus.flush = 1'b1; tick(); bus.flush = 1'b0;
  endtask

  task automatic test_reset();
    idle(); reset = 1'b1; tick(); tick(); reset = 1'b0;
    n_checks++; if (bus.count !== 3'd0) $display("FAIL reset_count got %0d want 0", bus.count); else n_pass++;
    n_checks++; if (bus.rd_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.rd_valid); else n_pass++;
    n_checks++; if (bus.full !== 1'b0) $display("FAIL reset_full got %b want 0", bus.full); else n_pass++;
    n_checks++; if (bus.ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", bus.ovf); else n_pass++;
    n_checks++; if (bus.rd_data !== 8'h00) $display("FAIL reset_data got %h want 00", bus.rd_data); else n_pass++;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] vals [3] = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++) begin
      push(vals[i]);
      n_checks++; if (bus.count !== 3'(i + 1)) $display("FAIL basic_count got %0d want %0d", bus.count, i + 1); else n_pass++;
      n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h11)
        $display("FAIL basic_head got v=%b d=%h want v=1 d=11", bus.rd_valid, bus.rd_data); else n_pass++;
      $display("push %h count=%0d", vals[i], bus.count);
    end
    bus.rd_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (bus.rd_data !== vals[i]) $display("FAIL basic_pop got %h want %h", bus.rd_data, vals[i]); else n_pass++;
      $display("pop %h", bus.rd_data);
      tick();
    end
    bus.rd_ack = 1'b0;
    n_checks++; if (bus.rd_valid !== 1'b0 || bus.count !== 3'd0)
      $display("FAIL basic_empty got v=%b c=%0d want v=0 c=0", bus.rd_valid, bus.count); else n_pass++;
  endtask

  task automatic test_overflow();
    do_flush();
    for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
    n_checks++; if (bus.full !== 1'b1 || bus.count !== 3'd4)
      $display("FAIL ovf_full got f=%b c=%0d want f=1 c=4", bus.full, bus.count); else n_pass++;
    push(8'hFF);
    n_checks++; if (bus.ovf !== 1'b1 || bus.count !== 3'd4)
      $display("FAIL ovf_set got o=%b c=%0d want o=1 c=4", bus.ovf, bus.count); else n_pass++;
    bus.rd_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bus.rd_data !== 8'hA0 + 8'(i)) $display("FAIL ovf_drain got %h want %h", bus.rd_data, 8'hA0 + 8'(i)); else n_pass++;
      $display("drain %h", bus.rd_data);
      tick();
    end
    bus.rd_ack = 1'b0;
    n_checks++; if (bus.ovf !== 1'b1 || bus.count !== 3'd0)
      $display("FAIL ovf_sticky got o=%b c=%0d want o=1 c=0", bus.ovf, bus.count); else n_pass++;
    do_flush();
    n_checks++; if (bus.ovf !== 1'b0 || bus.count !== 3'd0)
      $display("FAIL ovf_flush got o=%b c=%0d want o=0 c=0", bus.ovf, bus.count); else n_pass++;
  endtask

  task automatic test_full_pushpop();
    logic [WIDTH-1:0] exp_v [4] = '{8'hA1, 8'hA2, 8'hA3, 8'h55};
    do_flush();
    for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
    bus.wr_stb = 1'b1; bus.wr_data = 8'h55; bus.rd_ack = 1'b1;
    n_checks++; if (bus.rd_data !== 8'hA0) $display("FAIL fpp_head got %h want a0", bus.rd_data); else n_pass++;
    tick();
    bus.wr_stb = 1'b0;
    n_checks++; if (bus.count !== 3'd4 || bus.ovf !== 1'b0)
      $display("FAIL fpp_count got c=%0d o=%b want c=4 o=0", bus.count, bus.ovf); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bus.rd_data !== exp_v[i]) $display("FAIL fpp_pop got %h want %h", bus.rd_data, exp_v[i]); else n_pass++;
      $display("pop %h", bus.rd_data);
      tick();
    end
    bus.rd_ack = 1'b0;
  endtask

  task automatic test_wrap();
    do_flush();
    push(8'h00);
    for (int i = 1; i < 10; i++) begin
      bus.wr_stb = 1'b1; bus.wr_data = 8'(i); bus.rd_ack = 1'b1;
      n_checks++; if (bus.rd_data !== 8'(i - 1) || bus.count === 3'd0)
        $display("FAIL wrap_pop got d=%h c=%0d want d=%h c>0", bus.rd_data, bus.count, 8'(i - 1)); else n_pass++;
      $display("wrap push %h pop %h", 8'(i), bus.rd_data);
      tick();
    end
    bus.wr_stb = 1'b0;
    n_checks++; if (bus.rd_data !== 8'h09 || bus.count !== 3'd1)
      $display("FAIL wrap_last got d=%h c=%0d want d=09 c=1", bus.rd_data, bus.count); else n_pass++;
    tick();
    bus.rd_ack = 1'b0;
  endtask

  task automatic test_empty_pushpop();
    do_flush();
    bus.wr_stb = 1'b1; bus.wr_data = 8'h7E; bus.rd_ack = 1'b1;
    tick();
    idle();
    n_checks++; if (bus.count !== 3'd1 || bus.rd_data !== 8'h7E)
      $display("FAIL epp_push got c=%0d d=%h want c=1 d=7e", bus.count, bus.rd_data); else n_pass++;
    bus.rd_ack = 1'b1; tick(); tick(); bus.rd_ack = 1'b0;
    n_checks++; if (bus.count !== 3'd0) $display("FAIL epp_ack_empty got %0d want 0", bus.count); else n_pass++;
    $display("empty push/pop done");
  endtask

  task automatic test_reset_mid();
    do_flush();
    push(8'h01); push(8'h02); push(8'h03);
    bus.wr_stb = 1'b1; bus.wr_data = 8'h99; reset = 1'b1;
    tick();
    reset = 1'b0; bus.wr_stb = 1'b0;
    n_checks++; if (bus.count !== 3'd0 || bus.rd_valid !== 1'b0 || bus.ovf !== 1'b0)
      $display("FAIL rmid_state got c=%0d v=%b o=%b want 0 0 0", bus.count, bus.rd_valid, bus.ovf); else n_pass++;
    push(8'h42);
    n_checks++; if (bus.rd_data !== 8'h42 || bus.count !== 3'd1)
      $display("FAIL rmid_push got d=%h c=%0d want d=42 c=1", bus.rd_data, bus.count); else n_pass++;
    $display("reset mid-operation done");
  endtask

  task automatic test_random();
    int errs = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int stb_pct = (cyc / 50) % 2 == 0 ? 70 : 35;
      bus.wr_stb  = ($urandom_range(99) < stb_pct);
      bus.wr_data = 8'($urandom);
      bus.rd_ack  = ($urandom_range(99) < 50);
      bus.flush   = ($urandom_range(99) < 3);
      reset       = ($urandom_range(199) == 0);
      tick();
      n_checks++;
      if (bus.count !== 3'(model_q.size()) || bus.rd_valid !== (model_q.size() != 0) ||
          bus.full !== (model_q.size() == DEPTH) || bus.ovf !== model_ovf ||
          (model_q.size() != 0 && bus.rd_data !== model_q[0])) begin
        $display("FAIL rand_cyc%0d got c=%0d v=%b f=%b o=%b d=%h want c=%0d o=%b d=%h",
                 cyc, bus.count, bus.rd_valid, bus.full, bus.ovf, bus.rd_data,
                 model_q.size(), model_ovf, model_q.size() != 0 ? model_q[0] : 8'h00);
        errs++;
      end else n_pass++;
    end
    idle(); reset = 1'b0;
    $display("test_random done, %0d cycle errors", errs);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    model_ovf = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_full_pushpop();
    test_wrap();
    test_empty_pushpop();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
